// File: rtl/riscv_core_pkg.sv
`default_nettype none
// ============================================================================
// Module  : riscv_core_pkg
// Brief   : Shared core types: register/word types and writeback arbiter types
// Revision: 1.0 - initial release
// ============================================================================
package riscv_core_pkg;

    localparam int XLEN           = 32;
    localparam int REG_ADDR_WIDTH = 5;

    typedef logic [XLEN-1:0]           word_t;
    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HELD  = 2'd1,
        STALL = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
        word_t     data;
    } wb_req_t;

    localparam int WB_STARVE_LIMIT = 4;

endpackage
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : wb_arbiter
// Brief   : Merges pipeline WB and MDU results onto the single RF write port
// Revision: 1.0 - initial release
// ============================================================================
module wb_arbiter
    import riscv_core_pkg::*;
#(
    parameter int DATA_WIDTH     = XLEN,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int STARVE_LIMIT   = WB_STARVE_LIMIT
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      pipe_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] pipe_rd_addr_i,
    input  logic [DATA_WIDTH-1:0]     pipe_data_i,
    input  logic                      mdu_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] mdu_rd_addr_i,
    input  logic [DATA_WIDTH-1:0]     mdu_data_i,
    output logic                      mdu_ready_o,
    output logic                      stall_pipe_o,
    output logic                      write_en_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
    output logic [DATA_WIDTH-1:0]     rd_data_o
);

    localparam int          c_CNT_W     = 4;
    localparam [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STARVE_LIMIT - 1);

    wb_state_e                 r_state;
    wb_state_e                 w_state_nxt;
    logic [c_CNT_W-1:0]        r_starve_cnt;
    logic [c_CNT_W-1:0]        w_starve_cnt_nxt;
    logic                      r_stall;
    logic                      w_stall_nxt;
    logic [REG_ADDR_WIDTH-1:0] r_hold_rd;
    logic [DATA_WIDTH-1:0]     r_hold_data;
    logic                      r_we;
    logic [REG_ADDR_WIDTH-1:0] r_rd;
    logic [DATA_WIDTH-1:0]     r_data;

    logic w_pipe_wr;
    logic w_mdu_acc;
    logic w_capture;
    logic w_drain;

    assign w_pipe_wr   = pipe_valid_i && (pipe_rd_addr_i != '0);
    assign mdu_ready_o = (r_state == IDLE) && !rst_i;
    assign w_mdu_acc   = mdu_valid_i && mdu_ready_o;

    always_comb begin
        w_state_nxt      = r_state;
        w_starve_cnt_nxt = r_starve_cnt;
        w_stall_nxt      = 1'b0;
        w_capture        = 1'b0;
        w_drain          = 1'b0;
        case (r_state)
            IDLE: begin
                // An accepted MDU result aimed at x0 is simply dropped.
                if (w_mdu_acc && (mdu_rd_addr_i != '0)) begin
                    w_capture   = 1'b1;
                    w_state_nxt = HELD;
                end
            end
            HELD: begin
                if (w_pipe_wr) begin
                    w_starve_cnt_nxt = r_starve_cnt + 1'b1;
                    if (r_starve_cnt == c_CNT_LAST) begin
                        w_state_nxt = STALL;
                        w_stall_nxt = 1'b1;
                    end
                end else begin
                    w_drain          = 1'b1;
                    w_starve_cnt_nxt = '0;
                    w_state_nxt      = IDLE;
                end
            end
            STALL: begin
                w_drain          = 1'b1;
                w_starve_cnt_nxt = '0;
                w_state_nxt      = IDLE;
            end
            default: begin
                w_state_nxt      = IDLE;
                w_starve_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_stall      <= 1'b0;
            r_hold_rd    <= '0;
            r_hold_data  <= '0;
            r_we         <= 1'b0;
            r_rd         <= '0;
            r_data       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_cnt_nxt;
            r_stall      <= w_stall_nxt;
            if (w_capture) begin
                r_hold_rd   <= mdu_rd_addr_i;
                r_hold_data <= mdu_data_i;
            end
            // Pipeline owns the port; the hold only drains into an idle slot.
            if (w_pipe_wr) begin
                r_we   <= 1'b1;
                r_rd   <= pipe_rd_addr_i;
                r_data <= pipe_data_i;
            end else if (w_drain) begin
                r_we   <= 1'b1;
                r_rd   <= r_hold_rd;
                r_data <= r_hold_data;
            end else begin
                r_we <= 1'b0;
            end
        end
    end

    assign stall_pipe_o = r_stall;
    assign write_en_o   = r_we;
    assign rd_addr_o    = r_rd;
    assign rd_data_o    = r_data;

`ifndef SYNTHESIS
    a_upstream_stall: assert property (@(posedge clk_i) disable iff (rst_i)
        stall_pipe_o |-> !pipe_valid_i)
        else $error("wb_arbiter: pipe_valid_i asserted while stall_pipe_o high");

    a_no_x0_write: assert property (@(posedge clk_i) disable iff (rst_i)
        !(write_en_o && (rd_addr_o == '0)))
        else $error("wb_arbiter: write issued to x0");
`endif

endmodule
`default_nettype wire
